pio_edge_irq: RTL and testbench
===============================

PIO_EDGE_IRQ -- requirements
Module: pio_edge_irq

Interface
REQ-001 Parameter WIDTH, default 2, number of input bits; legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2, number of synchronizer flops per bit; legal range 2..4.
REQ-003 Parameter DEBOUNCE_CYCLES, default 0, number of stable clocks required before the debounced value changes; legal range 0..65535; 0 means bypass.
REQ-004 clk  input  1  single clock; all logic SHALL be on its rising edge.
REQ-005 reset_n  input  1  reset; synchronous and active-low.
REQ-006 address  input  3  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  32  write data.
REQ-010 in_port  input  WIDTH  asynchronous external inputs.
REQ-011 readdata  output  32  registered read data.
REQ-012 irq  output  1  level interrupt to the CPU.

Function
REQ-013 Each in_port bit SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is the synchronized value "sync".
REQ-014 The debounced value "db" SHALL equal sync, unless debounce is compiled in (REQ-030).
REQ-015 A registered copy "db_prev" SHALL hold db from the previous cycle.
REQ-016 Rise event = db & ~db_prev & rise_en; fall event = ~db & db_prev & fall_en.
REQ-017 Register map, word addresses:
- 0 data: read only, db.
- 1 rise_en: R/W.
- 2 irq_mask: R/W.
- 3 edge_capture: R/W1C.
- 4 fall_en: R/W.
- 5 irq_status: read only, edge_capture & irq_mask.
- 6..7: read 0, writes ignored.
REQ-018 A write SHALL occur when chipselect=1 and write_n=0; register bits above WIDTH are ignored on write and read as 0.
REQ-019 readdata SHALL be updated every clock with the mux output for the current address, giving 1-cycle read latency; zero-extend to 32 bits.
REQ-020 edge_capture[i] SHALL set on the clock after a rise or fall event on bit i, and SHALL hold until cleared.
REQ-021 A write to address 3 SHALL clear exactly the bits where writedata is 1; bits where writedata is 0 SHALL be unaffected.
REQ-022 If a clear and a new event coincide on the same bit, the set SHALL win and the bit stays 1.
REQ-023 irq SHALL be combinational |(edge_capture & irq_mask).
REQ-024 Clearing irq_mask SHALL deassert irq without altering edge_capture.
REQ-025 Latency, no debounce: an in_port change meeting setup before clock edge 1 SHALL set edge_capture at clock edge SYNC_STAGES+1.
REQ-026 With rise_en[i]=fall_en[i]=1, both edges SHALL be captured; with both 0, bit i SHALL never capture.

Reset
REQ-027 While reset_n=0 at a clock edge, the following SHALL load 0: readdata, rise_en, fall_en, irq_mask, edge_capture, all synchronizer stages, db, db_prev and debounce counters. irq SHALL therefore be 0.
REQ-028 An in_port bit held high through reset SHALL produce a rise event after reset release; this event is captured only if rise_en is set by then.
REQ-029 Reset asserted mid-debounce SHALL discard the partial count.

Configuration
REQ-030 With macro PIO_EDGE_IRQ_DEBOUNCE_EN defined, each bit SHALL have a 16-bit counter:
- The counter increments while sync != db.
- The counter returns to 0 when sync == db.
- db toggles and the counter returns to 0 when the counter reaches DEBOUNCE_CYCLES-1 with sync != db; this adds DEBOUNCE_CYCLES clocks of latency.
- DEBOUNCE_CYCLES=0 SHALL behave as bypass.
REQ-031 Without the macro, no counters SHALL be instantiated, db = sync, and DEBOUNCE_CYCLES SHALL be ignored.

Verification
REQ-032 Parameters WIDTH=4, SYNC_STAGES=2. Stimulus: rise_en=0xF, irq_mask=0x1, in_port 0->0x1. Required response: edge_capture=0x1 at edge 3; irq=1; read address 5 -> 0x1.
REQ-033 Stimulus: capture=0x5, write 0x4 to address 3. Required response: capture=0x1; irq stays high while mask bit 0 is set.
REQ-034 Stimulus: a write of 0x1 to address 3 in the same cycle as a new rise on bit 0. Required response: bit 0 stays 1.
REQ-035 Stimulus: fall_en=0x2, rise_en=0, in_port bit 1 goes 1->0->1. Required response: capture=0x2 only after the falling edge, with no set on the rise.
REQ-036 Macro defined, DEBOUNCE_CYCLES=8. Stimulus: a 5-cycle glitch. Required response: no capture. Stimulus: a 10-cycle pulse. Required response: capture set at edge SYNC_STAGES+8+1.
REQ-037 Stimulus: in_port=0x3 held through reset, then rise_en=0xF written in the first cycle after release. Required response: capture=0x3. Stimulus: reset asserted with capture=0xF. Required response: capture=0, irq=0, readdata=0 on the next edge.

Source files
------------

// File: rtl/pio_edge_irq.sv
// Avalon-MM PIO with synchronized inputs and per-bit rise/fall edge capture IRQ.
// Optional per-bit debounce filter is built when PIO_EDGE_IRQ_DEBOUNCE_EN is defined.
module pio_edge_irq #(
  parameter int WIDTH           = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_db;
  logic [WIDTH-1:0] r_db_prev;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic [31:0]      r_readdata;
  logic [31:0]      w_rdata;
  logic [WIDTH-1:0] w_wdata;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_event;
  logic [WIDTH-1:0] w_clr;
  logic             w_wr;
  logic             w_unused;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        r_sync[k] <= '0;
      end
    end else begin
      r_sync[0] <= in_port;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef PIO_EDGE_IRQ_DEBOUNCE_EN
  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_db_bypass
      assign w_db = w_sync;
    end else begin : g_db
      localparam logic [15:0] LIMIT = 16'(DEBOUNCE_CYCLES - 1);
      logic [15:0]      r_cnt [WIDTH];
      logic [WIDTH-1:0] r_db;

      // db flips only after sync has disagreed for DEBOUNCE_CYCLES clocks
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_db <= '0;
          for (int i = 0; i < WIDTH; i++) begin
            r_cnt[i] <= '0;
          end
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (w_sync[i] != r_db[i]) begin
              if (r_cnt[i] == LIMIT) begin
                r_db[i]  <= ~r_db[i];
                r_cnt[i] <= '0;
              end else begin
                r_cnt[i] <= r_cnt[i] + 16'd1;
              end
            end else begin
              r_cnt[i] <= '0;
            end
          end
        end
      end

      assign w_db = r_db;
    end
  endgenerate
`else
  assign w_db = w_sync;
`endif

  assign w_wr    = chipselect & ~write_n;
  assign w_wdata = writedata[WIDTH-1:0];
  assign w_rise  = w_db & ~r_db_prev & r_rise_en;
  assign w_fall  = ~w_db & r_db_prev & r_fall_en;
  assign w_event = w_rise | w_fall;
  assign w_clr   = (w_wr && address == 3'd3) ? w_wdata : '0;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_db_prev <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_mask    <= '0;
      r_cap     <= '0;
    end else begin
      r_db_prev <= w_db;
      // a same-cycle event beats the W1C clear
      r_cap     <= (r_cap & ~w_clr) | w_event;
      if (w_wr) begin
        unique case (1'b1)
          (address == 3'd1): r_rise_en <= w_wdata;
          (address == 3'd2): r_mask    <= w_wdata;
          (address == 3'd4): r_fall_en <= w_wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (address)
      3'd0:    w_rdata = 32'(w_db);
      3'd1:    w_rdata = 32'(r_rise_en);
      3'd2:    w_rdata = 32'(r_mask);
      3'd3:    w_rdata = 32'(r_cap);
      3'd4:    w_rdata = 32'(r_fall_en);
      3'd5:    w_rdata = 32'(r_cap & r_mask);
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else begin
      r_readdata <= w_rdata;
    end
  end

  assign readdata = r_readdata;
  assign irq      = |(r_cap & r_mask);
  assign w_unused = &{1'b0, writedata};

endmodule

// File: tb/tb_pio_edge_irq.sv
// Self-checking bench for pio_edge_irq: directed scenarios plus random traffic
// checked against a delay-line reference model of the input path.
module tb_pio_edge_irq;

  localparam int W = 4;
  localparam int S = 2;
`ifdef PIO_EDGE_IRQ_DEBOUNCE_EN
  localparam int DBC = 8;
`else
  localparam int DBC = 0;
`endif
  localparam int D = S + DBC;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [W-1:0] in_port;
  logic [31:0] readdata;
  logic        irq;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] m_rise, m_fall, m_mask, m_cap;
  logic [W-1:0] q[$];

  always #5 clk = ~clk;

  pio_edge_irq #(
    .WIDTH(W),
    .SYNC_STAGES(S),
    .DEBOUNCE_CYCLES(DBC)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Model: db is in_port delayed by D edges (inputs held >= DBC+1 cycles).
  task automatic tick();
    logic [W-1:0] db, dbp, ev, clr, wd;
    logic [31:0]  exp_rd;
    logic         wr;
    exp_rd = '0;
    if (!reset_n) begin
      foreach (q[i]) q[i] = '0;
      q.push_front('0);
      m_rise = '0; m_fall = '0; m_mask = '0; m_cap = '0;
    end else begin
      q.push_front(in_port);
      db  = q[D];
      dbp = q[D+1];
      case (address)
        3'd0: exp_rd = {28'b0, db};
        3'd1: exp_rd = {28'b0, m_rise};
        3'd2: exp_rd = {28'b0, m_mask};
        3'd3: exp_rd = {28'b0, m_cap};
        3'd4: exp_rd = {28'b0, m_fall};
        3'd5: exp_rd = {28'b0, m_cap & m_mask};
        default: exp_rd = '0;
      endcase
      ev  = (db & ~dbp & m_rise) | (~db & dbp & m_fall);
      wr  = chipselect && !write_n;
      wd  = writedata[W-1:0];
      clr = (wr && address == 3'd3) ? wd : '0;
      m_cap = (m_cap & ~clr) | ev;
      if (wr) begin
        case (address)
          3'd1: m_rise = wd;
          3'd2: m_mask = wd;
          3'd4: m_fall = wd;
          default: ;
        endcase
      end
    end
    while (q.size() > D + 2) void'(q.pop_back());
    @(posedge clk);
    #1;
    check("model_rdata", readdata, exp_rd);
    check("model_irq", {31'b0, irq}, {31'b0, |(m_cap & m_mask)});
  endtask

  task automatic raw_tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a,
                        input logic [31:0] exp);
    address = a;
    tick();
    check(tag, readdata, exp);
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = '0;
    for (int i = 0; i < D + 2; i++) q.push_front('0);
    m_rise = '0; m_fall = '0; m_mask = '0; m_cap = '0;
    repeat (3) tick();
    check("reset_rdata", readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    reset_n = 1'b1;
    tick();

    // rising edge capture and latency
    wr(3'd1, 32'hF);
    wr(3'd2, 32'h1);
    in_port = 4'h1;
    repeat (D) tick();
    check("rise_early", {31'b0, irq}, 32'h0);
    tick();
    check("rise_irq", {31'b0, irq}, 32'h1);
    rd_chk("status5", 3'd5, 32'h1);
    rd_chk("cap_1", 3'd3, 32'h1);

    // selective W1C
    in_port = 4'h5;
    repeat (D + 1) tick();
    rd_chk("cap_5", 3'd3, 32'h5);
    wr(3'd3, 32'hFFFF_FFF4);
    rd_chk("w1c_cap", 3'd3, 32'h1);
    check("w1c_irq", {31'b0, irq}, 32'h1);

    // mask clear drops irq, capture unchanged
    wr(3'd2, 32'h0);
    check("mask_irq", {31'b0, irq}, 32'h0);
    rd_chk("mask_cap", 3'd3, 32'h1);
    wr(3'd2, 32'h1);
    check("unmask_irq", {31'b0, irq}, 32'h1);
    rd_chk("data_rd", 3'd0, 32'h5);
    rd_chk("upper_rd", 3'd1, 32'hF);
    rd_chk("addr6", 3'd6, 32'h0);

    // clear colliding with new event: set wins
    wr(3'd3, 32'hF);
    in_port = 4'h0;
    repeat (D + 2) tick();
    rd_chk("cap_clear", 3'd3, 32'h0);
    in_port = 4'h1;
    repeat (D) tick();
    wr(3'd3, 32'h1);
    rd_chk("set_wins", 3'd3, 32'h1);

    // fall-only capture on bit 1
    wr(3'd3, 32'hF);
    wr(3'd1, 32'h0);
    wr(3'd4, 32'h2);
    in_port = 4'h2;
    repeat (D + 2) tick();
    rd_chk("no_rise", 3'd3, 32'h0);
    in_port = 4'h0;
    repeat (D) tick();
    rd_chk("fall_early", 3'd3, 32'h0);
    rd_chk("fall_cap", 3'd3, 32'h2);
    in_port = 4'h2;
    repeat (D + 2) tick();
    rd_chk("fall_only", 3'd3, 32'h2);

    // reset with all capture bits set
    wr(3'd1, 32'hF);
    wr(3'd2, 32'hF);
    in_port = 4'h0;
    repeat (D + 2) tick();
    in_port = 4'hF;
    repeat (D + 2) tick();
    rd_chk("cap_F", 3'd3, 32'hF);
    reset_n = 1'b0;
    tick();
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("rst_rdata", readdata, 32'h0);
    reset_n = 1'b1;
    rd_chk("rst_cap", 3'd3, 32'h0);

    // input held high through reset gives a rise after release
    in_port = 4'h3;
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    wr(3'd1, 32'hF);
    repeat (D + 2) tick();
    rd_chk("held_rise", 3'd3, 32'h3);

`ifdef PIO_EDGE_IRQ_DEBOUNCE_EN
    reset_n = 1'b0;
    in_port = 4'h0;
    tick();
    reset_n = 1'b1;
    wr(3'd1, 32'hF);
    wr(3'd2, 32'h1);
    repeat (4) tick();
    in_port = 4'h1;
    repeat (5) raw_tick();
    in_port = 4'h0;
    repeat (20) raw_tick();
    check("glitch", {31'b0, irq}, 32'h0);
    for (int t = 1; t <= 11; t++) begin
      in_port = (t <= 10) ? 4'h1 : 4'h0;
      raw_tick();
      if (t == 10) check("db_early", {31'b0, irq}, 32'h0);
      if (t == 11) check("db_lat", {31'b0, irq}, 32'h1);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
`endif

    // random traffic against the model
    for (int it = 0; it < 300; it++) begin
      int hold;
      in_port = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 24) == 0) begin
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
      end
      hold = $urandom_range(DBC + 1, DBC + 4);
      for (int h = 0; h < hold; h++) begin
        chipselect = 1'($urandom_range(0, 1));
        write_n    = ($urandom_range(0, 3) != 0);
        address    = 3'($urandom_range(0, 7));
        writedata  = $urandom;
        tick();
      end
    end
    chipselect = 1'b0;
    write_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
